// File: rtl/segre_hazard_ctrl.sv
// segre_hazard_ctrl: scoreboard-based RAW/stall/flush pipeline controller for the Segre core
// Optional forwarding support is enabled by defining SEGRE_FORWARDING_EN.
module segre_hazard_ctrl #(
  parameter int REG_SIZE     = 5,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                id_valid_i,
  input  logic [REG_SIZE-1:0] src_a_id_i,
  input  logic [REG_SIZE-1:0] src_b_id_i,
  input  logic                src_a_used_i,
  input  logic                src_b_used_i,
  input  logic                id_rf_we_i,
  input  logic [REG_SIZE-1:0] id_rf_waddr_i,
  input  logic                id_memop_rd_i,
  input  logic                br_taken_i,
  input  logic                mem_req_i,
  input  logic                mem_ready_i,
  output logic                block_if_o,
  output logic                block_id_o,
  output logic                inject_nops_o,
  output logic                stall_mem_o,
  output logic                valid_ex_o,
  output logic [1:0]          fwd_a_sel_o,
  output logic [1:0]          fwd_b_sel_o
);
  localparam int CW = $clog2(FLUSH_CYCLES + 1);
  typedef struct packed {
    logic                valid;
    logic                we;
    logic [REG_SIZE-1:0] waddr;
    logic                load;
  } sb_t;
  typedef enum logic [1:0] {RUN, MEM_WAIT, FLUSH} state_t;
  state_t        r_state, w_state_nx;
  logic [CW-1:0] r_cnt, w_cnt_nx;
  sb_t           r_sb [3];
  logic [2:0]    w_ma, w_mb;
  logic          w_raw, w_mstall, w_flush, w_blk, w_inj;
  logic [1:0]    w_fa, w_fb;
  for (genvar g = 0; g < 3; g++) begin : g_match
    assign w_ma[g] = id_valid_i & src_a_used_i & (src_a_id_i != '0) & r_sb[g].valid & r_sb[g].we & (r_sb[g].waddr == src_a_id_i);
    assign w_mb[g] = id_valid_i & src_b_used_i & (src_b_id_i != '0) & r_sb[g].valid & r_sb[g].we & (r_sb[g].waddr == src_b_id_i);
  end
`ifdef SEGRE_FORWARDING_EN
  assign w_raw = (w_ma[0] | w_mb[0]) & r_sb[0].load;
  assign w_fa  = w_raw ? 2'd0 : w_ma[0] ? 2'd1 : w_ma[1] ? 2'd2 : w_ma[2] ? 2'd3 : 2'd0;
  assign w_fb  = w_raw ? 2'd0 : w_mb[0] ? 2'd1 : w_mb[1] ? 2'd2 : w_mb[2] ? 2'd3 : 2'd0;
`else
  assign w_raw = |{w_ma, w_mb};
  assign w_fa  = 2'd0;
  assign w_fb  = 2'd0;
`endif
  // A FLUSH interrupted by a memory stall resumes its remaining count on the ready cycle
  assign w_mstall = (r_state == MEM_WAIT) ? !mem_ready_i : mem_req_i & !mem_ready_i;
  assign w_flush  = (r_state == RUN & br_taken_i) | (r_state == FLUSH) | (r_state == MEM_WAIT & r_cnt != '0);
  assign w_blk    = w_mstall | (!w_flush & w_raw);
  assign w_inj    = !w_mstall & (w_flush | w_raw);
  assign stall_mem_o   = !rst_i & w_mstall;
  assign block_if_o    = !rst_i & w_blk;
  assign block_id_o    = !rst_i & w_blk;
  assign inject_nops_o = !rst_i & w_inj;
  assign fwd_a_sel_o   = rst_i ? 2'd0 : w_fa;
  assign fwd_b_sel_o   = rst_i ? 2'd0 : w_fb;
  assign valid_ex_o    = r_sb[0].valid;
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    if (w_mstall)
      w_state_nx = MEM_WAIT;
    else if (r_state == RUN & br_taken_i & FLUSH_CYCLES > 1) begin
      w_state_nx = FLUSH;
      w_cnt_nx   = CW'(FLUSH_CYCLES - 1);
    end else if (r_state == FLUSH | r_cnt != '0) begin
      w_state_nx = (r_cnt > CW'(1)) ? FLUSH : RUN;
      w_cnt_nx   = (r_cnt > CW'(1)) ? r_cnt - CW'(1) : '0;
    end else
      w_state_nx = RUN;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= RUN;
      r_cnt   <= '0;
      r_sb[0] <= '0;
      r_sb[1] <= '0;
      r_sb[2] <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      if (!w_mstall) begin
        r_sb[0] <= (w_inj | w_blk) ? '0 : {id_valid_i, id_rf_we_i, id_rf_waddr_i, id_memop_rd_i};
        r_sb[1] <= r_sb[0];
        r_sb[2] <= r_sb[1];
      end
    end
  end
endmodule

// File: tb/tb_segre_hazard_ctrl.sv
// tb_segre_hazard_ctrl: directed self-checking bench for segre_hazard_ctrl
module tb_segre_hazard_ctrl;
`ifdef SEGRE_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  logic       clk_i = 1'b0, rst_i;
  logic       id_valid_i, src_a_used_i, src_b_used_i, id_rf_we_i, id_memop_rd_i;
  logic [4:0] src_a_id_i, src_b_id_i, id_rf_waddr_i;
  logic       br_taken_i, mem_req_i, mem_ready_i;
  logic       block_if_o, block_id_o, inject_nops_o, stall_mem_o, valid_ex_o;
  logic [1:0] fwd_a_sel_o, fwd_b_sel_o;
  logic [3:0] ctrl;
  int         n_cmp = 0, n_err = 0;
  assign ctrl = {block_if_o, block_id_o, inject_nops_o, stall_mem_o};
  always #5 clk_i = ~clk_i;
  segre_hazard_ctrl #(.REG_SIZE(5), .FLUSH_CYCLES(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .id_valid_i(id_valid_i),
    .src_a_id_i(src_a_id_i), .src_b_id_i(src_b_id_i),
    .src_a_used_i(src_a_used_i), .src_b_used_i(src_b_used_i),
    .id_rf_we_i(id_rf_we_i), .id_rf_waddr_i(id_rf_waddr_i), .id_memop_rd_i(id_memop_rd_i),
    .br_taken_i(br_taken_i), .mem_req_i(mem_req_i), .mem_ready_i(mem_ready_i),
    .block_if_o(block_if_o), .block_id_o(block_id_o), .inject_nops_o(inject_nops_o),
    .stall_mem_o(stall_mem_o), .valid_ex_o(valid_ex_o),
    .fwd_a_sel_o(fwd_a_sel_o), .fwd_b_sel_o(fwd_b_sel_o)
  );
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask
  task automatic setid(input logic v, input logic [4:0] a, input logic au, input logic [4:0] b,
                       input logic bu, input logic we, input logic [4:0] wa, input logic ld);
    id_valid_i = v; src_a_id_i = a; src_a_used_i = au; src_b_id_i = b; src_b_used_i = bu;
    id_rf_we_i = we; id_rf_waddr_i = wa; id_memop_rd_i = ld;
  endtask
  initial begin
    rst_i = 1'b1; br_taken_i = 1'b1; mem_req_i = 1'b1; mem_ready_i = 1'b0;
    setid(1, 5'd3, 1, 5'd3, 1, 1, 5'd3, 0);
    #3;
    chk("rst_ctrl", ctrl, 4'h0);
    chk("rst_vex", valid_ex_o, 0);
    chk("rst_fwd", {fwd_a_sel_o, fwd_b_sel_o}, 0);
    br_taken_i = 0; mem_req_i = 0;
    setid(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    rst_i = 0;
    #1;
    chk("idle_ctrl", ctrl, 4'h0);
    chk("idle_vex", valid_ex_o, 0);
    setid(1, 5'd0, 1, 5'd0, 0, 1, 5'd5, 0);
    #1;
    chk("addi_ctrl", ctrl, 4'h0);
    tick();
    chk("addi_vex", valid_ex_o, 1);
    setid(1, 5'd5, 1, 5'd1, 1, 1, 5'd6, 0);
    for (int i = 1; i <= 3; i++) begin
      #1;
      chk($sformatf("add_raw%0d", i), ctrl, FWD ? 4'h0 : 4'hE);
      chk($sformatf("add_fwda%0d", i), fwd_a_sel_o, FWD ? 8'(i) : 8'd0);
      chk($sformatf("add_fwdb%0d", i), fwd_b_sel_o, 0);
      tick();
    end
    #1;
    chk("add_clear", ctrl, 4'h0);
    tick();
    setid(1, 0, 0, 0, 0, 1, 5'd0, 0);
    tick();
    setid(1, 5'd0, 1, 5'd0, 1, 0, 5'd0, 0);
    #1;
    chk("x0_c1", ctrl, 4'h0);
    tick();
    chk("x0_c2", ctrl, 4'h0);
    setid(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("bubble_vex", valid_ex_o, 0);
    setid(1, 0, 0, 0, 0, 1, 5'd9, 0);
    mem_req_i = 1; mem_ready_i = 0;
    for (int i = 1; i <= 4; i++) begin
      #1;
      chk($sformatf("mst_ctrl%0d", i), ctrl, 4'hD);
      chk($sformatf("mst_vex%0d", i), valid_ex_o, 0);
      tick();
    end
    mem_ready_i = 1;
    #1;
    chk("mst_ready", ctrl, 4'h0);
    tick();
    chk("mst_resume_vex", valid_ex_o, 1);
    chk("mreq_rdy_same", ctrl, 4'h0);
    tick();
    mem_req_i = 0; mem_ready_i = 0;
    setid(1, 0, 0, 0, 0, 1, 5'd10, 0);
    tick();
    setid(1, 5'd10, 1, 5'd2, 1, 1, 5'd12, 0);
    br_taken_i = 1;
    #1;
    chk("br_raw_c1", ctrl, 4'h2);
    tick();
    br_taken_i = 0;
    #1;
    chk("br_raw_c2", ctrl, 4'h2);
    tick();
    chk("br_raw_after", ctrl, FWD ? 4'h0 : 4'hE);
    setid(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    br_taken_i = 1;
    #1;
    chk("brm_c1", ctrl, 4'h2);
    tick();
    br_taken_i = 0; mem_req_i = 1; mem_ready_i = 0;
    #1;
    chk("brm_stall1", ctrl, 4'hD);
    tick();
    chk("brm_stall2", ctrl, 4'hD);
    mem_ready_i = 1;
    #1;
    chk("brm_resume_flush", ctrl, 4'h2);
    tick();
    mem_req_i = 0; mem_ready_i = 0;
    #1;
    chk("brm_run", ctrl, 4'h0);
    setid(1, 0, 0, 0, 0, 1, 5'd11, 0);
    tick();
    chk("rmf_vex_pre", valid_ex_o, 1);
    br_taken_i = 1;
    #1;
    chk("rmf_br", ctrl, 4'h2);
    tick();
    br_taken_i = 0;
    #1;
    chk("rmf_flush", ctrl, 4'h2);
    rst_i = 1;
    #1;
    chk("rmf_rst_ctrl", ctrl, 4'h0);
    chk("rmf_rst_vex", valid_ex_o, 0);
    tick();
    rst_i = 0;
    setid(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("rmf_run_ctrl", ctrl, 4'h0);
    chk("rmf_run_vex", valid_ex_o, 0);
    setid(1, 0, 0, 0, 0, 1, 5'd7, 1);
    tick();
    setid(1, 5'd7, 1, 5'd7, 1, 1, 5'd8, 0);
    #1;
    chk("lu_c1", ctrl, 4'hE);
    chk("lu_c1_fwd", {fwd_a_sel_o, fwd_b_sel_o}, 0);
    tick();
    chk("lu_c2", ctrl, FWD ? 4'h0 : 4'hE);
    chk("lu_c2_fwd", {fwd_a_sel_o, fwd_b_sel_o}, FWD ? 4'hA : 4'h0);
    tick();
    chk("lu_c3", ctrl, FWD ? 4'h0 : 4'hE);
    chk("lu_c3_fwd", {fwd_a_sel_o, fwd_b_sel_o}, FWD ? 4'hF : 4'h0);
    tick();
    chk("lu_c4", ctrl, 4'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/segre_hazard_ctrl.md
# segre_hazard_ctrl

Pipeline controller for the Segre in-order core. It tracks in-flight register writers in a three-entry scoreboard (EX, MEM, WB) and detects read-after-write hazards against the ID stage source identifiers. It also sequences data-memory stalls and taken-branch flushes. It drives the ID stage's `block_id_i`/`inject_nops_i` controls, the IF stage's block control and the EX/MEM freeze.

## Interface
Parameters:
- `REG_SIZE`, 5, register identifier width
- `FLUSH_CYCLES`, 2, bubbles injected per taken branch (≥1)

Ports:
- `clk_i` in 1: clock, rising edge
- `rst_i` in 1: reset, asynchronous, active-high
- `id_valid_i` in 1: ID holds a valid instruction
- `src_a_id_i`, `src_b_id_i` in REG_SIZE: ID source register identifiers
- `src_a_used_i`, `src_b_used_i` in 1: corresponding source is read
- `id_rf_we_i` in 1: ID instruction writes the register file
- `id_rf_waddr_i` in REG_SIZE: ID destination register
- `id_memop_rd_i` in 1: ID instruction is a load
- `br_taken_i` in 1: EX resolved a taken branch/jump this cycle
- `mem_req_i` in 1: MEM issues a data-memory access
- `mem_ready_i` in 1: data memory completes the access this cycle
- `block_if_o` out 1: hold PC/fetch
- `block_id_o` out 1: hold the ID pipeline register
- `inject_nops_o` out 1: load NOP into ID and bubble into EX
- `stall_mem_o` out 1: freeze EX, MEM and WB registers
- `valid_ex_o` out 1: EX holds a valid instruction
- `fwd_a_sel_o`, `fwd_b_sel_o` out 2: forward select (0 RF, 1 EX, 2 MEM, 3 WB)

## Operation
- Scoreboard entry: {valid, we, waddr, load}. `sb[0]`=EX, `sb[1]`=MEM, `sb[2]`=WB.
- Scoreboard advances each cycle unless `stall_mem_o`:
  - `sb[0]` ← bubble (all zero) if `inject_nops_o` or `block_id_o`; otherwise ← {`id_valid_i`, `id_rf_we_i`, `id_rf_waddr_i`, `id_memop_rd_i`}.
  - `sb[i]` ← `sb[i-1]`.
  - The WB entry retires.
- Match on source s: `id_valid_i` & s_used & s≠0 & entry.valid & entry.we & entry.waddr==s. Writes to x0 never match.
- `raw` = match, by the configured rule (see Configuration), of any used source.
- States:
  - RUN: default state.
    - Goes to MEM_WAIT if `mem_req_i & !mem_ready_i`.
    - Otherwise goes to FLUSH if `br_taken_i` and FLUSH_CYCLES>1, with counter ← FLUSH_CYCLES-1.
  - MEM_WAIT: goes to RUN on `mem_ready_i`. `br_taken_i` is ignored; EX is frozen and re-presents the branch after the stall.
  - FLUSH: counter decrements each cycle and the state returns to RUN when the counter reaches 1. Memory stall has priority: the state goes to MEM_WAIT and the remaining count is kept.
- Output priority in the same cycle: memory stall > flush > RAW > run.
  - Memory stall (state MEM_WAIT, or RUN/FLUSH with `mem_req_i & !mem_ready_i`): `stall_mem_o`=`block_if_o`=`block_id_o`=1, `inject_nops_o`=0.
  - Flush (`br_taken_i` in RUN, or state FLUSH): `inject_nops_o`=1 and blocks=0, so the PC redirect loads. Flush overrides a RAW hazard.
  - RAW: `block_if_o`=`block_id_o`=1, `inject_nops_o`=1.
  - Otherwise all four controls are 0.
- `valid_ex_o` = `sb[0].valid` (registered).

## Timing
- Reset: state RUN, counter 0, all scoreboard entries invalid.
- During reset all outputs are 0, including combinational ones.
- Control outputs are combinational from state, scoreboard and same-cycle inputs, with zero-cycle latency.
- The scoreboard, state and counter update on the rising edge.
- `mem_req_i & mem_ready_i` in the same cycle causes no stall.
- Reset mid-stall or mid-flush returns to RUN immediately and clears the scoreboard.

## Configuration
- `SEGRE_FORWARDING_EN` defined:
  - `raw` uses load-use only: a match on `sb[0]` with load=1, so a load followed by a dependent instruction costs 1 bubble.
  - `fwd_*_sel_o` selects the youngest matching entry (EX>MEM>WB) and is 0 when a RAW stall is asserted.
- Not defined:
  - `raw` is a match on any of `sb[0..2]`.
  - `fwd_*_sel_o` is tied to 0.

## Test plan
- Reset asserted mid-FLUSH with counter 1 → next cycle all outputs 0, state RUN, `valid_ex_o`=0.
- `addi x5` then `add x6,x5,x1`:
  - Without forwarding: 3 cycles of `block_id_o`=1/`inject_nops_o`=1.
  - With forwarding: 0 stall cycles and `fwd_a_sel_o`=1.
- `lw x7` then `add x8,x7,x7`:
  - With forwarding: exactly 1 stall cycle, then `fwd_a_sel_o`=`fwd_b_sel_o`=2.
  - Writes to x0 followed by reads of x0 produce no stall.
- `mem_req_i`=1 with `mem_ready_i` low for 4 cycles → `stall_mem_o` high exactly 4 cycles, scoreboard unchanged, and resumption on the ready cycle.
- `br_taken_i` pulse with FLUSH_CYCLES=2 while a RAW hazard is present → `inject_nops_o`=1 for 2 cycles with `block_if_o`=0.
- `mem_req_i` stall arriving in FLUSH → the remaining flush cycle completes after `mem_ready_i`.
